// File: rtl/regfile_pkg.sv
// Shared widths, register constants and FSM state type for the register-file write arbiter.
package regfile_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] ZERO_REG      = 5'd31;
    localparam logic [REG_W-1:0] LAST_INIT_REG = 5'd30;

    typedef enum logic {S_INIT, S_RUN} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int  N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             anyGnt
);
    int cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        anyGnt = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!anyGnt && req[cand]) begin
                anyGnt    = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port; sweeps INIT_VALUE into X0..X30 after reset.
// REGFILE_ARB_FWD_EN adds fwd_valid/fwd_reg/fwd_data bypass outputs.
//   state  | meaning
//   S_INIT | staging INIT_VALUE into X0..X30, one register per cycle, no grants
//   S_RUN  | arbitrating requesters, one registered write per cycle
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int                NUM_REQ    = 2,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][REG_W-1:0]     req_reg,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic                              stall,
    output logic                              init_done,
    output logic                              regWriteEnable,
    output logic [REG_W-1:0]                  writeReg,
    output logic [DATA_W-1:0]                 writeData
`ifdef REGFILE_ARB_FWD_EN
    ,
    output logic                              fwd_valid,
    output logic [REG_W-1:0]                  fwd_reg,
    output logic [DATA_W-1:0]                 fwd_data
`endif
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, stateNext;
    logic [REG_W-1:0]   sweepCnt, sweepNext;
    logic [IDX_W-1:0]   ptr, ptrNext;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gntIdx;
    logic               anyGnt;
    logic               weNext;
    logic [REG_W-1:0]   regNext;
    logic [DATA_W-1:0]  dataNext;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .idx    (gntIdx),
        .anyGnt (anyGnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_INIT;
            sweepCnt       <= '0;
            ptr            <= '0;
            regWriteEnable <= 1'b0;
            writeReg       <= '0;
            writeData      <= '0;
        end else begin
            state          <= stateNext;
            sweepCnt       <= sweepNext;
            ptr            <= ptrNext;
            regWriteEnable <= weNext;
            writeReg       <= regNext;
            writeData      <= dataNext;
        end
    end

    always_comb begin
        stateNext = state;
        sweepNext = sweepCnt;
        ptrNext   = ptr;
        weNext    = 1'b0;
        regNext   = writeReg;
        dataNext  = writeData;
        req_ready = '0;
        case (state)
            S_INIT: begin
                weNext    = 1'b1;
                regNext   = sweepCnt;
                dataNext  = INIT_VALUE;
                sweepNext = sweepCnt + 1'b1;
                if (sweepCnt == LAST_INIT_REG)
                    stateNext = S_RUN;
            end
            S_RUN: begin
                if (!stall && anyGnt) begin
                    req_ready = gnt;
                    ptrNext   = (gntIdx == IDX_W'(NUM_REQ - 1)) ? '0 : gntIdx + 1'b1;
                    regNext   = req_reg[gntIdx];
                    dataNext  = req_data[gntIdx];
                    // X31 is hardwired zero: accept the request but never write it
                    weNext    = (req_reg[gntIdx] != ZERO_REG);
                end
            end
            default: stateNext = S_INIT;
        endcase
    end

    assign init_done = (state == S_RUN);

`ifdef REGFILE_ARB_FWD_EN
    assign fwd_valid = regWriteEnable;
    assign fwd_reg   = writeReg;
    assign fwd_data  = writeData;
`endif
endmodule
